bnn_param_loader: RTL and testbench

- Runtime parameter-load sequencer for the binarised MNIST classifier (conv1 → conv2 → fc).
- Replaces backdoor memory preloading with a streamed, handshaked load of kernel words and bias offsets, one layer at a time.
- Drives the classifier top's kernel/offset write ports and reports per-layer load status.
- `params_ready` gates image acceptance downstream.

---
 rtl/bnn_param_loader_if.sv | 31 +++
 rtl/bnn_param_loader.sv | 198 +++++++++++++++++++
 tb/tb_bnn_param_loader.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_param_loader_if.sv
// Parameter stream (source -> loader) and classifier write port (loader -> classifier)
// bundled for the BNN parameter loader.
interface bnn_param_loader_if #(
  parameter int WORD_W = 25,
  parameter int ADDR_W = 11,
  parameter int OFF_W  = 9
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              kernel_in_valid;
  logic              offset_in_valid;
  logic [1:0]        kernel_layer;
  logic [ADDR_W-1:0] kernel_addr;
  logic [WORD_W-1:0] kernel_word;
  logic [OFF_W-1:0]  kernel_offset;

  modport master (
    output in_valid, in_data,
    input  in_ready,
    input  kernel_in_valid, offset_in_valid, kernel_layer,
    input  kernel_addr, kernel_word, kernel_offset
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready,
    output kernel_in_valid, offset_in_valid, kernel_layer,
    output kernel_addr, kernel_word, kernel_offset
  );
endinterface

// File: rtl/bnn_param_loader.sv
// Streams kernel words then bias offsets for one classifier layer at a time into the
// classifier write ports, tracking which layers are fully loaded.
module bnn_param_loader #(
  parameter int WORD_W = 25,
  parameter int ADDR_W = 11,
  parameter int OFF_W  = 9,
  parameter int KW_L1  = 90,
  parameter int BW_L1  = 18,
  parameter int KW_L2  = 1080,
  parameter int BW_L2  = 60,
  parameter int KW_L3  = 390,
  parameter int BW_L3  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic [1:0]            cfg_layer,
  input  logic                  cfg_abort,
  output logic                  cfg_ready,
  bnn_param_loader_if.slave     bus,
  output logic [2:0]            loaded,
  output logic                  params_ready,
  output logic                  err_cfg
);

  localparam longint ADDR_LIM = 64'sd1 <<< ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  function automatic bit count_ok(input int n);
    return (n >= 32'sd1) && (longint'(n) < ADDR_LIM);
  endfunction

  generate
    if (!(count_ok(KW_L1) && count_ok(BW_L1) && count_ok(KW_L2) &&
          count_ok(BW_L2) && count_ok(KW_L3) && count_ok(BW_L3))) begin : g_bad_cfg
      $error("bnn_param_loader: word counts must be >= 1 and < 2**ADDR_W");
    end
  endgenerate

  function automatic logic [ADDR_W-1:0] kw_last(input logic [1:0] layer);
    case (layer)
      2'd1:    kw_last = ADDR_W'(KW_L1 - 32'sd1);
      2'd2:    kw_last = ADDR_W'(KW_L2 - 32'sd1);
      2'd3:    kw_last = ADDR_W'(KW_L3 - 32'sd1);
      default: kw_last = '0;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] bw_last(input logic [1:0] layer);
    case (layer)
      2'd1:    bw_last = ADDR_W'(BW_L1 - 32'sd1);
      2'd2:    bw_last = ADDR_W'(BW_L2 - 32'sd1);
      2'd3:    bw_last = ADDR_W'(BW_L3 - 32'sd1);
      default: bw_last = '0;
    endcase
  endfunction

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_KERN = 2'd1, ST_BIAS = 2'd2} state_t;

  state_t            state_r, state_nx_s;
  logic [ADDR_W-1:0] cnt_r, cnt_nx_s;
  logic [1:0]        cur_layer_r, cur_layer_nx_s;
  logic [2:0]        loaded_r, loaded_nx_s;
  logic              err_cfg_r, err_cfg_nx_s;
  logic              kwr_r, kwr_nx_s;
  logic              owr_r, owr_nx_s;
  logic [1:0]        wlayer_r, wlayer_nx_s;
  logic [ADDR_W-1:0] waddr_r, waddr_nx_s;
  logic [WORD_W-1:0] wword_r, wword_nx_s;
  logic [OFF_W-1:0]  woff_r, woff_nx_s;

  logic in_ready_s, hs_s, start_ok_s, kern_done_s, bias_done_s;

  assign in_ready_s  = (state_r == ST_KERN) || (state_r == ST_BIAS);
  assign hs_s        = bus.in_valid & in_ready_s;
  assign start_ok_s  = (state_r == ST_IDLE) && cfg_start && (cfg_layer != 2'd0);
  assign kern_done_s = hs_s && (state_r == ST_KERN) && (cnt_r == kw_last(cur_layer_r));
  assign bias_done_s = hs_s && (state_r == ST_BIAS) && (cnt_r == bw_last(cur_layer_r));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // next-state decode; abort overrides count completion
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: if (start_ok_s) state_nx_s = ST_KERN; else state_nx_s = ST_IDLE;
      ST_KERN: begin
        if (cfg_abort)        state_nx_s = ST_IDLE;
        else if (kern_done_s) state_nx_s = ST_BIAS;
        else                  state_nx_s = ST_KERN;
      end
      ST_BIAS: begin
        if (cfg_abort || bias_done_s) state_nx_s = ST_IDLE;
        else                          state_nx_s = ST_BIAS;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // next values of counter, status and the registered write port
  always_comb begin
    cnt_nx_s       = cnt_r;
    cur_layer_nx_s = cur_layer_r;
    loaded_nx_s    = loaded_r;
    kwr_nx_s       = 1'b0;
    owr_nx_s       = 1'b0;
    wlayer_nx_s    = wlayer_r;
    waddr_nx_s     = waddr_r;
    wword_nx_s     = wword_r;
    woff_nx_s      = woff_r;
    if (cfg_start && ((state_r != ST_IDLE) || (cfg_layer == 2'd0))) err_cfg_nx_s = 1'b1;
    else                                                           err_cfg_nx_s = err_cfg_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          cnt_nx_s                        = '0;
          cur_layer_nx_s                  = cfg_layer;
          loaded_nx_s[cfg_layer - 2'd1]   = 1'b0;
        end else begin
          cnt_nx_s = cnt_r;
        end
      end
      ST_KERN: begin
        if (hs_s) begin
          kwr_nx_s    = 1'b1;
          wlayer_nx_s = cur_layer_r;
          waddr_nx_s  = cnt_r;
          wword_nx_s  = bus.in_data;
          if (kern_done_s) cnt_nx_s = '0;
          else             cnt_nx_s = cnt_r + CNT_ONE;
        end else begin
          kwr_nx_s = 1'b0;
        end
      end
      ST_BIAS: begin
        if (hs_s) begin
          owr_nx_s    = 1'b1;
          wlayer_nx_s = cur_layer_r;
          waddr_nx_s  = cnt_r;
          woff_nx_s   = bus.in_data[OFF_W-1:0];
          cnt_nx_s    = cnt_r + CNT_ONE;
          if (bias_done_s && !cfg_abort) loaded_nx_s[cur_layer_r - 2'd1] = 1'b1;
          else                           loaded_nx_s = loaded_r;
        end else begin
          owr_nx_s = 1'b0;
        end
      end
      default: cnt_nx_s = '0;
    endcase
  end

  // datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= '0;
      cur_layer_r <= 2'd0;
      loaded_r    <= 3'd0;
      err_cfg_r   <= 1'b0;
      kwr_r       <= 1'b0;
      owr_r       <= 1'b0;
      wlayer_r    <= 2'd0;
      waddr_r     <= '0;
      wword_r     <= '0;
      woff_r      <= '0;
    end else begin
      cnt_r       <= cnt_nx_s;
      cur_layer_r <= cur_layer_nx_s;
      loaded_r    <= loaded_nx_s;
      err_cfg_r   <= err_cfg_nx_s;
      kwr_r       <= kwr_nx_s;
      owr_r       <= owr_nx_s;
      wlayer_r    <= wlayer_nx_s;
      waddr_r     <= waddr_nx_s;
      wword_r     <= wword_nx_s;
      woff_r      <= woff_nx_s;
    end
  end

  assign cfg_ready           = (state_r == ST_IDLE);
  assign bus.in_ready        = in_ready_s;
  assign bus.kernel_in_valid = kwr_r;
  assign bus.offset_in_valid = owr_r;
  assign bus.kernel_layer    = wlayer_r;
  assign bus.kernel_addr     = waddr_r;
  assign bus.kernel_word     = wword_r;
  assign bus.kernel_offset   = woff_r;
  assign loaded              = loaded_r;
  assign params_ready        = &loaded_r;
  assign err_cfg             = err_cfg_r;

endmodule

// File: tb/tb_bnn_param_loader.sv
// Directed bench for bnn_param_loader: streams tagged words per layer and checks every
// write, the load status, error flag, abort and asynchronous reset behaviour.
module tb_bnn_param_loader;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_start, cfg_abort, cfg_ready;
  logic [1:0] cfg_layer;
  logic [2:0] loaded;
  logic       params_ready, err_cfg;

  bnn_param_loader_if #(.WORD_W(25), .ADDR_W(11), .OFF_W(9)) bus ();

  bnn_param_loader dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_layer(cfg_layer), .cfg_abort(cfg_abort),
    .cfg_ready(cfg_ready), .bus(bus),
    .loaded(loaded), .params_ready(params_ready), .err_cfg(err_cfg)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int wr_cnt  = 0;
  int cyc     = 0;
  int first_cyc, last_cyc;
  int mon_layer = 1;
  int mon_k = 0;
  int mon_b = 0;
  logic [2:0] loaded_m = 3'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int kw(input int l);
    case (l)
      1: return 90;
      2: return 1080;
      3: return 390;
      default: return 0;
    endcase
  endfunction

  function automatic int bw(input int l);
    case (l)
      1: return 18;
      2: return 60;
      3: return 10;
      default: return 0;
    endcase
  endfunction

  // word tag: layer, kind (0 kernel / 1 bias), index, and a scrambled low field
  function automatic logic [24:0] gen(input int l, input int k, input int i);
    logic [10:0] a;
    a = 11'(i * 7 + l * 3);
    return {2'(l), 1'(k), 11'(i), a};
  endfunction

  task automatic monitor();
    logic [24:0] exp_w;
    logic [8:0]  exp_o;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.kernel_in_valid || bus.offset_in_valid) begin
        chk("one_strobe", 32'(bus.kernel_in_valid & bus.offset_in_valid), 32'd0);
        wr_cnt++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        chk("wr_layer", 32'(bus.kernel_layer), 32'(mon_layer));
        if (bus.kernel_in_valid) begin
          chk("k_addr", 32'(bus.kernel_addr), 32'(mon_k));
          exp_w = gen(mon_layer, 0, mon_k);
          chk("k_word", 32'(bus.kernel_word), 32'(exp_w));
          mon_k++;
        end else begin
          chk("k_before_b", 32'(mon_k), 32'(kw(mon_layer)));
          chk("b_addr", 32'(bus.kernel_addr), 32'(mon_b));
          exp_w = gen(mon_layer, 1, mon_b);
          exp_o = exp_w[8:0];
          chk("b_off", 32'(bus.kernel_offset), 32'(exp_o));
          if (mon_b == bw(mon_layer) - 1) loaded_m[mon_layer-1] = 1'b1;
          mon_b++;
        end
        chk("wr_loaded", 32'(loaded), 32'(loaded_m));
        chk("wr_pready", 32'(params_ready), 32'(&loaded_m));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int l);
    chk("start_rdy", 32'(cfg_ready), 32'd1);
    cfg_start = 1'b1;
    cfg_layer = 2'(l);
    tick();
    cfg_start = 1'b0;
    mon_layer = l;
    mon_k = 0;
    mon_b = 0;
    first_cyc = -1;
    loaded_m[l-1] = 1'b0;
  endtask

  task automatic send(input logic [24:0] d, input int idle_pct, input bit poke);
    while (idle_pct > 0 && $urandom_range(0, 99) < idle_pct) begin
      bus.in_valid = 1'b0;
      tick();
    end
    chk("in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    if (poke) begin
      cfg_start = 1'b1;
      cfg_layer = 2'd2;
    end
    tick();
    bus.in_valid = 1'b0;
    cfg_start    = 1'b0;
  endtask

  task automatic load(input int l, input int idle_pct, input int poke_at, input int abort_at);
    int n;
    logic [24:0] d;
    n = kw(l) + bw(l);
    start(l);
    for (int i = 0; i < n; i++) begin
      if (i < kw(l)) d = gen(l, 0, i);
      else           d = gen(l, 1, i - kw(l));
      send(d, idle_pct, i == poke_at);
      if (i == abort_at) begin
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        break;
      end
    end
    tick();
    tick();
  endtask

  initial begin
    int w0;
    rst_n = 1'b0;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    cfg_layer = 2'd0;
    bus.in_valid = 1'b0;
    bus.in_data  = 25'd0;
    first_cyc = -1;
    last_cyc  = 0;
    fork
      monitor();
    join_none
    repeat (3) tick();
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_loaded", 32'(loaded), 32'd0);
    chk("rst_pready", 32'(params_ready), 32'd0);
    chk("rst_err", 32'(err_cfg), 32'd0);
    chk("rst_strobes", 32'({bus.kernel_in_valid, bus.offset_in_valid}), 32'd0);
    chk("rst_addr", 32'(bus.kernel_addr), 32'd0);
    chk("rst_word", 32'(bus.kernel_word), 32'd0);
    chk("rst_off", 32'(bus.kernel_offset), 32'd0);
    chk("rst_layer", 32'(bus.kernel_layer), 32'd0);
    rst_n = 1'b1;
    tick();

    // conv1 with in_valid held high: 108 gap-free writes
    w0 = wr_cnt;
    load(1, 0, -1, -1);
    chk("c1_writes", 32'(wr_cnt - w0), 32'd108);
    chk("c1_span", 32'(last_cyc - first_cyc + 1), 32'd108);
    chk("c1_loaded", 32'(loaded), 32'b001);

    // layer 0 request in IDLE
    chk("err_before", 32'(err_cfg), 32'd0);
    cfg_start = 1'b1;
    cfg_layer = 2'd0;
    tick();
    cfg_start = 1'b0;
    chk("l0_err", 32'(err_cfg), 32'd1);
    chk("l0_idle", 32'(cfg_ready), 32'd1);
    chk("l0_in_ready", 32'(bus.in_ready), 32'd0);

    // all three layers with random idle cycles
    w0 = wr_cnt;
    load(1, 30, -1, -1);
    load(2, 30, -1, -1);
    chk("seq_pready_mid", 32'(params_ready), 32'd0);
    load(3, 30, -1, -1);
    chk("seq_writes", 32'(wr_cnt - w0), 32'd1648);
    chk("seq_pready", 32'(params_ready), 32'd1);

    // cfg_start during conv2 kernel word 500 is ignored
    load(2, 0, 500, -1);
    chk("poke_err", 32'(err_cfg), 32'd1);
    chk("poke_loaded", 32'(loaded), 32'b111);

    // abort after conv2 bias word 30, then reload
    load(2, 0, -1, 1080 + 30);
    chk("abort_idle", 32'(cfg_ready), 32'd1);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
    chk("abort_loaded", 32'(loaded), 32'b101);
    chk("abort_bias_cnt", 32'(mon_b), 32'd31);
    w0 = wr_cnt;
    bus.in_valid = 1'b1;
    repeat (8) tick();
    bus.in_valid = 1'b0;
    chk("abort_no_wr", 32'(wr_cnt - w0), 32'd0);
    load(2, 0, -1, -1);
    chk("reload_loaded", 32'(loaded), 32'b111);

    // reload of a loaded layer drops params_ready at acceptance
    chk("all_pready", 32'(params_ready), 32'd1);
    start(1);
    chk("rel_loaded", 32'(loaded), 32'b110);
    chk("rel_pready", 32'(params_ready), 32'd0);

    // asynchronous reset mid-BIAS with a bias strobe active
    for (int i = 0; i < 95; i++) begin
      if (i < 90) send(gen(1, 0, i), 0, 1'b0);
      else        send(gen(1, 1, i - 90), 0, 1'b0);
    end
    #2;
    chk("pre_rst_strobe", 32'(bus.offset_in_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    loaded_m = 3'd0;
    chk("arst_kstrobe", 32'(bus.kernel_in_valid), 32'd0);
    chk("arst_ostrobe", 32'(bus.offset_in_valid), 32'd0);
    chk("arst_loaded", 32'(loaded), 32'd0);
    chk("arst_pready", 32'(params_ready), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("arst_cfg_ready", 32'(cfg_ready), 32'd1);
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    w0 = wr_cnt;
    bus.in_valid = 1'b1;
    repeat (10) tick();
    bus.in_valid = 1'b0;
    chk("post_rst_no_wr", 32'(wr_cnt - w0), 32'd0);
    chk("post_rst_idle", 32'(cfg_ready), 32'd1);
    chk("post_rst_loaded", 32'(loaded), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
